// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard feeding reg_gnt_ckr: records issue locks, clears them on writeback,
// and forces all-locked during a blocking phase. Optional macro: REG_LOCK_TRACKER_WB_BYPASS_EN.
module reg_lock_tracker #(
  parameter int NR  = 32,
  parameter int NWB = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic                              flush_i,
  input  logic                              issue_fire_i,
  input  logic                              issue_blocking_i,
  input  logic [NR-1:0]                     issue_locks_i,
  input  logic [NWB-1:0]                    wb_valid_i,
  input  logic [NWB*$clog2(NR)-1:0]         wb_rd_i,
  input  logic                              blk_done_i,
  output logic [NR-1:0]                     locks_o,
  output logic                              issue_ready_o,
  output logic                              busy_o,
  output logic                              wb_err_o
);

  localparam int RW = $clog2(NR);

  typedef enum logic {ST_RUN, ST_BLOCK} state_t;

  state_t          state_reg;
  logic [NR-1:0]   real_reg;
  logic [NR-1:0]   real_next;
  logic            err_reg;
  logic            ready_reg;

  logic [NWB-1:0][NR-1:0] port_mask;
  logic [NWB-1:0]         port_err;
  logic [NR-1:0]          wb_mask;
  logic [NR-1:0]          issue_mask;
  logic [NR-1:0]          new_mask;
  logic                   wb_hit_err;

  function automatic logic [NR-1:0] decode_rd(input logic valid, input logic [RW-1:0] rd);
    logic [NR-1:0] m;
    m = '0;
    for (int r = 0; r < NR; r++) begin
      if (valid && (rd == RW'(r))) m[r] = 1'b1;
    end
    return m;
  endfunction

  // An out-of-range index decodes to no bit and therefore also reports an error.
  for (genvar gi = 0; gi < NWB; gi++) begin : g_wb
    assign port_mask[gi] = decode_rd(wb_valid_i[gi], wb_rd_i[gi*RW +: RW]);
    assign port_err[gi]  = wb_valid_i[gi] && ((port_mask[gi] & real_reg) == '0);
  end

  always_comb begin
    wb_mask = '0;
    for (int k = 0; k < NWB; k++) wb_mask = wb_mask | port_mask[k];
    wb_mask[0] = 1'b0;
  end

  assign wb_hit_err = |port_err;

`ifdef REG_LOCK_TRACKER_WB_BYPASS_EN
  assign locks_o = (state_reg == ST_BLOCK) ? '1 : (real_reg & ~wb_mask);
`else
  assign locks_o = (state_reg == ST_BLOCK) ? '1 : real_reg;
`endif

  always_comb begin
    issue_mask    = issue_locks_i;
    issue_mask[0] = 1'b0;
    new_mask      = issue_mask & ~locks_o;
  end

  // Bits the issuing instruction asks for survive a same-cycle writeback: the new producer wins.
  assign real_next = (real_reg & ~(wb_mask & ~issue_mask)) | new_mask;

  assign issue_ready_o = ready_reg;
  assign busy_o        = (|real_reg) | (state_reg == ST_BLOCK);
  assign wb_err_o      = err_reg;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= ST_RUN;
      real_reg  <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
    end else if (flush_i) begin
      state_reg <= ST_RUN;
      real_reg  <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      err_reg <= err_reg | wb_hit_err;
      case (state_reg)
        ST_RUN: begin
          if (issue_fire_i && issue_blocking_i) begin
            real_reg  <= real_reg & ~wb_mask;
            state_reg <= ST_BLOCK;
            ready_reg <= 1'b0;
          end else if (issue_fire_i) begin
            real_reg <= real_next;
          end else begin
            real_reg <= real_reg & ~wb_mask;
          end
        end
        ST_BLOCK: begin
          real_reg <= real_reg & ~wb_mask;
          if (blk_done_i) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule
